inst_fetch_queue: RTL

Prefetch stage directly upstream of the single-cycle datapath's decode/execute logic. It issues word-address requests to a latency-variable instruction memory over a req/ack handshake. Returned words are buffered with their PCs in a small FIFO and presented downstream on a valid/ready interface. On a taken branch, jump or jr redirect, the FIFO is flushed and fetching restarts at the new PC.

---
 rtl/inst_fetch_queue.sv | 125 ++++++++++++
 1 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction prefetch queue: req/ack fetch from imem, PC-tagged FIFO, valid/ready out, redirect flush.
// Optional FETCHQ_STATS_EN adds stall_cycles / squash_count saturating counters.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
`ifdef FETCHQ_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] squash_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, SQUASH} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [29:0]   squash_addr;
  logic [31:0]   mem_inst [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;

  assign push       = (state == REQ) && imem_ack && !redirect;
  assign pop        = inst_valid && inst_ready && !redirect;
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  assign imem_req   = (state != IDLE);
  // A squashed request keeps its original address until the memory acks it.
  assign imem_addr  = (state == SQUASH) ? squash_addr : fetch_pc[31:2];
  assign inst_valid = (count != '0);
  assign inst       = mem_inst[rd_ptr];
  assign inst_pc    = mem_pc[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      squash_addr <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst[i] <= '0;
        mem_pc[i]   <= '0;
      end
    end else if (redirect) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= redirect_pc & ~32'h3;
      case (state)
        REQ: begin
          if (imem_ack) begin
            state <= IDLE;
          end else begin
            state       <= SQUASH;
            squash_addr <= fetch_pc[31:2];
          end
        end
        SQUASH: begin
          if (imem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end else begin
      if (push) begin
        mem_inst[wr_ptr] <= imem_data;
        mem_pc[wr_ptr]   <= fetch_pc;
        wr_ptr           <= wr_ptr + 1'b1;
        fetch_pc         <= fetch_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      // Space is reserved at issue time, so an accepted ack always has a slot.
      case (state)
        IDLE: begin
          if (count_next < FULL) state <= REQ;
        end
        REQ: begin
          if (imem_ack) state <= (count_next < FULL) ? REQ : IDLE;
        end
        SQUASH: begin
          if (imem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCHQ_STATS_EN
  logic squash_evt;
  assign squash_evt = imem_ack && ((state == SQUASH) || ((state == REQ) && redirect));

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      squash_count <= '0;
    end else begin
      if (!inst_valid && !redirect && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (squash_evt && (squash_count != '1)) squash_count <= squash_count + 16'd1;
    end
  end
`endif

endmodule
